btn_conditioner: RTL
====================

# btn_conditioner

Input conditioning stage ahead of the ALU register bank: takes raw, asynchronous, bouncing push-button levels and delivers clean one-cycle load strobes. Each button is synchronized, debounced with a stability counter, and rising-edge detected. Output `o_btn_pulse` drives the ALU top's `i_btn` directly, so each physical press loads A, B or OP exactly once.

## Interface
- `NB_BTN`, 3: number of buttons conditioned (bit 0 = load A, bit 1 = load B, bit 2 = load OP).
- `DEBOUNCE_CYCLES`, 1000000: consecutive stable cycles required to accept a new level (10 ms at 100 MHz). Must be ≥ 2.
- `NB_CNT`, 20: debounce counter width. Must satisfy 2^NB_CNT > DEBOUNCE_CYCLES.
- `clk`, in, 1: single system clock; all logic is on its rising edge.
- `rst_n`, in, 1: asynchronous, active-high reset.
- `i_btn_raw`, in, NB_BTN: raw button levels, asynchronous to `clk`, high = pressed.
- `o_btn_pulse`, out, NB_BTN: one-cycle strobe per accepted press.
- `o_btn_level`, out, NB_BTN: debounced button level.

## Operation
- All bits are independent and identical. There is no arbitration between bits; simultaneous pulses pass through, and downstream priority (A > B > OP) resolves them.
- Synchronizer: two flip-flops per bit, `s1 <= i_btn_raw`, `s2 <= s1`. Only `s2` is used downstream.
- Debounce state per bit: `stable` (drives `o_btn_level`) and counter `cnt`.
  - `s2 == stable`: `cnt <= 0`.
  - `s2 != stable` and `cnt < DEBOUNCE_CYCLES-1`: `cnt <= cnt+1`.
  - `s2 != stable` and `cnt == DEBOUNCE_CYCLES-1`: `stable <= s2`, `cnt <= 0`.
- Any single cycle with `s2 == stable` clears `cnt`, so a glitch shorter than `DEBOUNCE_CYCLES` never changes `stable`.
- Pulse: `o_btn_pulse` is a register set to 1 for exactly one cycle, on the edge where `stable` goes 0→1, and 0 otherwise. A release (1→0) produces no pulse.
- Holding the button produces one pulse only. A new pulse requires a debounced release followed by a debounced press.
- Counter never wraps; its maximum value is `DEBOUNCE_CYCLES-1`.

## Timing
- Reset values, held while `rst_n` = 1: `s1`, `s2`, `stable`, `cnt` = 0; `o_btn_pulse` = 0; `o_btn_level` = 0.
- Latency, clean step on `i_btn_raw` first sampled at edge 1:
  - `s2` changes at edge 2.
  - `cnt` counts at edges 3..D+1 (D = `DEBOUNCE_CYCLES`).
  - `stable` and `o_btn_pulse` rise at edge D+2.
  - `o_btn_pulse` falls at edge D+3.
- Release latency is identical (D+2 edges) for `o_btn_level`.
- Reset mid-count discards the partial count.
- Button held through reset deassertion: `stable` starts at 0, so one pulse is emitted D+2 edges after the first post-reset edge.
- Outputs are fully registered; there is no combinational path from `i_btn_raw`.

## Structure
- Shared package `btn_pkg` holds:
  - `NB_BTN` default and the named bit indices `BTN_LOAD_A` = 0, `BTN_LOAD_B` = 1, `BTN_LOAD_OP` = 2.
  - `DEBOUNCE_CYCLES` default and the clock-frequency constant it derives from.
- Sub-module `debounce_bit` contains the synchronizer, counter, stable register and pulse register for one bit. `btn_conditioner` instantiates `NB_BTN` copies in a generate loop and has no other logic.

## Test plan
All scenarios use `DEBOUNCE_CYCLES` = 4, `NB_CNT` = 3.
- Reset: `rst_n` = 1 with `i_btn_raw` = 3'b111 → both outputs 0 throughout; after release, `o_btn_pulse` = 3'b111 for one cycle at edge 6, `o_btn_level` = 3'b111.
- Clean press on bit 0 held for 20 cycles → `o_btn_pulse` = 3'b001 exactly once, 6 edges after the first sampled edge; `o_btn_level[0]` stays 1 until a release is debounced.
- Bounce: bit 1 toggles 1,0,1,1,0,1 on consecutive cycles, then held high → no pulse during the bounce; single pulse 6 edges after the last 0→1 transition.
- Glitch: bit 2 high for 3 cycles, then low → no pulse; `o_btn_level` stays 3'b000.
- Simultaneous: bits 0 and 1 pressed on the same cycle → `o_btn_pulse` = 3'b011 for one cycle; release then press bit 0 again → second pulse 3'b001.
- Reset mid-count: press bit 0, assert `rst_n` at edge 4 for 2 cycles, keep the button held → no pulse before reset; one pulse 6 edges after reset deassertion.

Source files
------------

// File: rtl/btn_pkg.sv
`default_nettype none
// ============================================================================
// Module   : btn_pkg
// Purpose  : Shared constants for the push-button conditioning stage: button
//            count, named bit indices into the button vector, and the default
//            debounce interval derived from the system clock frequency.
// Revision : 1.0 - initial release
// ============================================================================
package btn_pkg;

  // Button vector layout, matching the ALU register bank load strobes.
  localparam int DEF_NB_BTN  = 3;
  localparam int BTN_LOAD_A  = 0;
  localparam int BTN_LOAD_B  = 1;
  localparam int BTN_LOAD_OP = 2;

  // Debounce interval: 10 ms at the 100 MHz system clock.
  localparam int CLK_FREQ_HZ         = 100_000_000;
  localparam int DEBOUNCE_MS         = 10;
  localparam int DEF_DEBOUNCE_CYCLES = (CLK_FREQ_HZ / 1000) * DEBOUNCE_MS;
  localparam int DEF_NB_CNT          = 20;

endpackage : btn_pkg
`default_nettype wire

// File: rtl/debounce_bit.sv
`default_nettype none
// ============================================================================
// Module   : debounce_bit
// Purpose  : Conditions one raw push-button level: two-flop synchronizer,
//            stability-counter debouncer, and a registered one-cycle strobe
//            on each debounced press (0->1 of the stable level).
// Ports    : clk       - system clock, rising edge
//            rst_n     - asynchronous reset, ACTIVE-HIGH despite its name
//            btn_raw   - raw asynchronous button level, high = pressed
//            btn_pulse - one-cycle strobe per accepted press (registered)
//            btn_level - debounced level (registered)
// Revision : 1.0 - initial release
// ============================================================================
module debounce_bit
  import btn_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int NB_CNT          = DEF_NB_CNT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_raw,
  output logic btn_pulse,
  output logic btn_level
);

  localparam logic [NB_CNT-1:0] CNT_MAX = NB_CNT'(DEBOUNCE_CYCLES - 1);

  logic              s1;
  logic              s2;
  logic              stable;
  logic [NB_CNT-1:0] cnt;

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      s1        <= 1'b0;
      s2        <= 1'b0;
      stable    <= 1'b0;
      cnt       <= '0;
      btn_pulse <= 1'b0;
    end else begin
      s1        <= btn_raw;
      s2        <= s1;
      btn_pulse <= 1'b0;
      if (s2 == stable) begin
        // Any agreeing cycle restarts the stability window.
        cnt <= '0;
      end else if (cnt == CNT_MAX) begin
        stable    <= s2;
        cnt       <= '0;
        // s2 differs from stable here, so s2 == 1 means a 0->1 transition.
        btn_pulse <= s2;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  assign btn_level = stable;

endmodule : debounce_bit
`default_nettype wire

// File: rtl/btn_conditioner.sv
`default_nettype none
// ============================================================================
// Module   : btn_conditioner
// Purpose  : Converts NB_BTN raw bouncing push-button levels into clean
//            one-cycle load strobes for the ALU register bank. Bits are
//            independent; simultaneous strobes pass through unarbitrated.
// Ports    : clk         - system clock, rising edge
//            rst_n       - asynchronous reset, ACTIVE-HIGH despite its name
//            i_btn_raw   - raw asynchronous button levels [NB_BTN]
//            o_btn_pulse - one-cycle strobe per accepted press [NB_BTN]
//            o_btn_level - debounced button levels [NB_BTN]
// Revision : 1.0 - initial release
// ============================================================================
module btn_conditioner
  import btn_pkg::*;
#(
  parameter int NB_BTN          = DEF_NB_BTN,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int NB_CNT          = DEF_NB_CNT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NB_BTN-1:0] i_btn_raw,
  output logic [NB_BTN-1:0] o_btn_pulse,
  output logic [NB_BTN-1:0] o_btn_level
);

  for (genvar g = 0; g < NB_BTN; g++) begin : g_bit
    debounce_bit #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .NB_CNT          (NB_CNT)
    ) u_debounce_bit (
      .clk       (clk),
      .rst_n     (rst_n),
      .btn_raw   (i_btn_raw[g]),
      .btn_pulse (o_btn_pulse[g]),
      .btn_level (o_btn_level[g])
    );
  end : g_bit

endmodule : btn_conditioner
`default_nettype wire
